// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single write port of the register file between two requesters
//   (0 = bus-side master, 1 = core writeback) with round-robin arbitration.
//   Accepted writes inside BASE..BASE+NREG-1 are driven to the register file
//   one cycle after acceptance. Out-of-window writes raise a one-cycle err
//   pulse instead. Committed writes are counted.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   req0_valid/addr/data      requester 0 write request
//   req0_ready                requester 0 accepted this cycle (combinational)
//   req1_valid/addr/data      requester 1 write request
//   req1_ready                requester 1 accepted this cycle (combinational)
//   W_addr, wData, we         registered register-file write port
//   err                       one-cycle pulse for an out-of-window accepted write
//   last_gnt                  index of the most recently granted requester
//   wr_cnt                    committed-write count, wraps modulo 2^CW
module rf_write_arbiter #(
  parameter int              AW   = 16,
  parameter int              DW   = 64,
  parameter logic [AW-1:0]   BASE = 16'h0100,
  parameter int              NREG = 10,
  parameter int              CW   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [AW-1:0] W_addr,
  output logic [DW-1:0] wData,
  output logic          we,
  output logic          err,
  output logic          last_gnt,
  output logic [CW-1:0] wr_cnt
);

  localparam logic [AW-1:0] LAST = BASE + AW'(NREG - 1);

  logic          gnt0;
  logic          gnt1;
  logic          accept;
  logic          in_win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // A sole requester always wins; under contention the one that did not win
  // last time wins. Readies are forced low while reset is asserted.
  always_comb begin
    gnt0     = reset_n && req0_valid && (!req1_valid || last_gnt);
    gnt1     = reset_n && req1_valid && (!req0_valid || !last_gnt);
    accept   = gnt0 || gnt1;
    sel_addr = gnt1 ? req1_addr : req0_addr;
    sel_data = gnt1 ? req1_data : req0_data;
    in_win   = (sel_addr >= BASE) && (sel_addr <= LAST);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      W_addr   <= '0;
      wData    <= '0;
      we       <= 1'b0;
      err      <= 1'b0;
      last_gnt <= 1'b1;
      wr_cnt   <= '0;
    end else begin
      we  <= 1'b0;
      err <= 1'b0;
      if (accept) begin
        last_gnt <= gnt1;
        if (in_win) begin
          W_addr <= sel_addr;
          wData  <= sel_data;
          we     <= 1'b1;
          wr_cnt <= wr_cnt + CW'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic [AW-1:0] W_addr;
  logic [DW-1:0] wData;
  logic          we;
  logic          err;
  logic          last_gnt;
  logic [CW-1:0] wr_cnt;

  int checks = 0;
  int failures = 0;

  rf_write_arbiter #(.AW(AW), .DW(DW), .BASE(16'h0100), .NREG(10), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .W_addr(W_addr), .wData(wData), .we(we), .err(err), .last_gnt(last_gnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // One record per cycle: readies seen before the edge, outputs after it.
  typedef struct packed {
    logic          r0;
    logic          r1;
    logic          we;
    logic          err;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  logic          m_we, m_err, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cnt;

  task automatic model_reset();
    m_we = 0; m_err = 0; m_last = 1; m_addr = '0; m_data = '0; m_cnt = '0;
  endtask

  // Runs one clock with the inputs currently driven; starts and ends just after a rising edge.
  task automatic cycle();
    rec_t e, o;
    logic g0, g1;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    o.r0 = req0_ready;
    o.r1 = req1_ready;
    g0 = reset_n && req0_valid && (!req1_valid || m_last);
    g1 = reset_n && req1_valid && (!req0_valid || !m_last);
    e.r0 = g0;
    e.r1 = g1;
    if (!reset_n) begin
      model_reset();
    end else if (g0 || g1) begin
      a = g1 ? req1_addr : req0_addr;
      d = g1 ? req1_data : req0_data;
      m_last = g1;
      if (a >= 16'h0100 && a <= 16'h0109) begin
        m_we = 1; m_err = 0; m_addr = a; m_data = d; m_cnt = m_cnt + 1'b1;
      end else begin
        m_we = 0; m_err = 1;
      end
    end else begin
      m_we = 0; m_err = 0;
    end
    @(posedge clk);
    #1;
    o.we = we; o.err = err; o.last = last_gnt; o.addr = W_addr; o.data = wData; o.cnt = wr_cnt;
    e.we = m_we; e.err = m_err; e.last = m_last; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic do_reset();
    req0_valid = 0;
    req1_valid = 0;
    reset_n = 0;
    model_reset();
    cycle();
    cycle();
    reset_n = 1;
  endtask

  task automatic test_reset();
    rec_t e, o;
    do_reset();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_single_write();
    rec_t e, o;
    do_reset();
    req0_valid = 1; req0_addr = 16'h0103; req0_data = 64'hDEAD_BEEF_0000_0001;
    cycle();
    req0_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL single_write got=%h exp=%h", o, e); end
    end
    checks++;
    if ({we, W_addr, wData, wr_cnt, last_gnt} !== {1'b1, 16'h0103, 64'hDEAD_BEEF_0000_0001, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_write_fields got we=%b addr=%h data=%h cnt=%0d last=%b", we, W_addr, wData, wr_cnt, last_gnt);
    end
    cycle();
    void'(exp_q.pop_front()); void'(obs_q.pop_front());
  endtask

  task automatic test_round_robin();
    rec_t e, o;
    logic [3:0] order = '0;
    do_reset();
    req0_addr = 16'h0100; req0_data = 64'h0000_0000_0000_00A0;
    req1_addr = 16'h0109; req1_data = 64'h0000_0000_0000_00B1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req1_valid = 1;
      cycle();
      order[i] = last_gnt;
      if (!last_gnt) req0_data = req0_data + 64'h100;
    end
    req0_valid = 0; req1_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL round_robin got=%h exp=%h", o, e); end
    end
    checks++;
    if (order !== 4'b1010 || wr_cnt !== 4'd4) begin
      failures++; $display("FAIL rr_order got order=%b cnt=%0d exp order=1010 cnt=4", order, wr_cnt);
    end
  endtask

  task automatic test_out_of_window();
    rec_t e, o;
    logic [AW-1:0] bad [4] = '{16'h010A, 16'h00FF, 16'h0000, 16'h0200};
    logic [AW-1:0] addr0;
    logic [CW-1:0] cnt0;
    addr0 = W_addr;
    cnt0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1; req1_addr = bad[i]; req1_data = 64'h5555_0000_0000_0000 + 64'(i);
      cycle();
    end
    req1_valid = 0;
    cycle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL out_of_window got=%h exp=%h", o, e); end
    end
    checks++;
    if (W_addr !== addr0 || wr_cnt !== cnt0 || last_gnt !== 1'b1 || we !== 1'b0) begin
      failures++; $display("FAIL oow_hold got addr=%h cnt=%0d last=%b exp addr=%h cnt=%0d last=1", W_addr, wr_cnt, last_gnt, addr0, cnt0);
    end
  endtask

  task automatic test_withdraw();
    rec_t e, o;
    logic [CW-1:0] cnt0;
    do_reset();
    req0_valid = 1; req0_addr = 16'h0101; req0_data = 64'h11;
    cycle();
    req1_valid = 1; req1_addr = 16'h0102; req1_data = 64'h22;
    req0_addr = 16'h0104; req0_data = 64'h44;
    cycle();
    req1_addr = 16'h0105; req1_data = 64'h55;
    cycle();
    req1_addr = 16'h0106; req1_data = 64'h66;
    req0_addr = 16'h0107; req0_data = 64'h77;
    cycle();
    cnt0 = wr_cnt;
    req0_valid = 0; req1_valid = 0;
    cycle();
    cycle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL withdraw got=%h exp=%h", o, e); end
    end
    checks++;
    if (wr_cnt !== 4'd4 || cnt0 !== 4'd4 || W_addr !== 16'h0106) begin
      failures++; $display("FAIL withdraw_final got cnt=%0d addr=%h exp cnt=4 addr=0106", wr_cnt, W_addr);
    end
  endtask

  task automatic test_reset_midstream();
    rec_t e, o;
    req0_valid = 1; req0_addr = 16'h0108; req0_data = 64'hABCD;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", req0_ready); end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({req0_ready, we, err, last_gnt, W_addr, wData, wr_cnt} !== {4'b0001, 16'h0, 64'h0, 4'd0}) begin
      failures++; $display("FAIL mid_reset_outputs got rdy=%b we=%b last=%b addr=%h cnt=%0d", req0_ready, we, last_gnt, W_addr, wr_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (we !== 1'b0 || W_addr !== 16'h0 || last_gnt !== 1'b1) begin
      failures++; $display("FAIL mid_dropped got we=%b addr=%h last=%b exp we=0 addr=0000 last=1", we, W_addr, last_gnt);
    end
    model_reset();
    reset_n = 1;
    req1_valid = 1; req1_addr = 16'h0100; req1_data = 64'h1;
    cycle();
    req0_valid = 0; req1_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL mid_restart got=%h exp=%h", o, e); end
    end
    checks++;
    if (last_gnt !== 1'b0 || W_addr !== 16'h0108) begin
      failures++; $display("FAIL mid_first_grant got last=%b addr=%h exp last=0 addr=0108", last_gnt, W_addr);
    end
  endtask

  task automatic test_wrap();
    rec_t e, o;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1; req0_addr = 16'h0100 + 16'(i % 10); req0_data = 64'(i);
      cycle();
    end
    req0_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap got=%h exp=%h", o, e); end
    end
    checks++;
    if (wr_cnt !== 4'd0 || we !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL wrap_final got cnt=%0d we=%b err=%b exp cnt=0 we=1 err=0", wr_cnt, we, err);
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_out_of_window();
    test_withdraw();
    test_reset_midstream();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 10-entry, 64-bit register file between two requesters.
  - Requester 0: the bus-side master.
  - Requester 1: the core writeback path.
- Round-robin arbitration with a valid/ready handshake on each requester.
- Range-checks the 16-bit register address against the register-file window 0x0100–0x0109.
- Drives registered W_addr / wData / we into the register file one cycle after acceptance; flags out-of-window writes; counts committed writes.

Parameters:
- AW, 16, address width (matches register-file W_addr).
- DW, 64, data width (matches register-file wData).
- BASE, 16'h0100, address of register 0.
- NREG, 10, number of registers; the valid window is BASE .. BASE+NREG-1.
- CW, 16, width of the committed-write counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  AW  requester 0 target address.
- req0_data  in  DW  requester 0 write data.
- req0_ready  out  1  requester 0 accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  AW  requester 1 target address.
- req1_data  in  DW  requester 1 write data.
- req1_ready  out  1  requester 1 accepted this cycle (combinational).
- W_addr  out  AW  register-file write address (registered).
- wData  out  DW  register-file write data (registered).
- we  out  1  register-file write enable (registered, single-cycle pulse per write).
- err  out  1  one-cycle pulse: an accepted write had an out-of-window address.
- last_gnt  out  1  index of the most recently granted requester.
- wr_cnt  out  CW  count of committed (we=1) writes, wraps modulo 2^CW.

Behaviour:
- Reset (asynchronous, reset_n=0): W_addr=0, wData=0, we=0, err=0, last_gnt=1 (so requester 0 wins the first contention), wr_cnt=0. Ready outputs are 0 while in reset.
- Arbitration (combinational, every cycle):
  - Only one valid → that requester gets ready=1.
  - Both valid → the requester != last_gnt gets ready=1; the other gets 0.
  - Neither valid → both readies 0.
  - At most one ready is ever high.
- Acceptance = valid & ready on the same rising edge. A requester must hold valid, addr and data stable until accepted. Dropping valid before acceptance is legal (the request is withdrawn, with no side effects).
- On the edge of acceptance of requester g with address A and data D:
  - last_gnt <= g.
  - If BASE <= A <= BASE+NREG-1: W_addr <= A, wData <= D, we <= 1, err <= 0, wr_cnt <= wr_cnt+1.
  - Otherwise: we <= 0, err <= 1; W_addr, wData and wr_cnt hold.
- No acceptance on an edge: we <= 0, err <= 0; W_addr, wData, last_gnt and wr_cnt hold.
- Latency: exactly 1 cycle from the acceptance edge to we high. Throughput is one write per cycle; back-to-back accepts produce back-to-back we pulses.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; neither requester waits more than one cycle.
- A requester that is the sole valid requester is granted regardless of last_gnt. last_gnt still updates to it.
- Range checks use full AW-bit unsigned compares; addresses such as 0x0000, 0x00FF, 0x010A and 0x0200 are out of window.
- wr_cnt wraps from 2^CW-1 to 0 without flagging.
- Reset asserted mid-stream: all outputs go to their reset values immediately. An accepted-but-uncommitted write (we due next cycle) is dropped. After release, arbitration restarts with requester 0 preferred.
- The arbiter has no read path; the register-file read ports are untouched by this block.

Test Plan:
- Reset, then req0 alone writes 0x0103/0xDEAD_BEEF_0000_0001 → req0_ready=1 in the same cycle. Next cycle: we=1, W_addr=0x0103, wData=0xDEADBEEF00000001, wr_cnt=1, last_gnt=0.
- After reset, both valid every cycle for 4 cycles (req0 → 0x0100, req1 → 0x0109) → grant order 0,1,0,1. we high on 4 consecutive cycles with W_addr alternating 0x0100/0x0109. wr_cnt=4. req1 stalls until granted and holds its data.
- req1 alone writes 0x010A, then 0x00FF → two err pulses, we stays 0, W_addr and wr_cnt unchanged, last_gnt=1.
- req0 valid for 2 cycles and then withdrawn, while req1 has priority and is also valid → req1 accepted first, req0 accepted the next cycle. Withdrawing req0 before its grant produces no we.
- Accept a write and assert reset_n=0 before the next edge → we never pulses. All outputs read 0 and last_gnt=1 during reset. After release, contention grants req0 first.
- Preload wr_cnt to 0xFFFF via 65535 valid writes (or use a CW=4 build with 15 writes), then one more write → wr_cnt=0, we=1 for that write.
